// File: rtl/fetch_sequencer_pkg.sv
// ============================================================================
// Module      : fetch_sequencer_pkg
// Description : Shared constants and fetch state encoding for the RISC front end.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_sequencer_pkg;

   localparam int          DEF_ADDR_W  = 6;
   localparam int          DEF_WORD_W  = 24;
   localparam int          DEF_DEPTH   = 2;
   localparam logic [3:0]  DEF_HALT_OP = 4'hF;
   localparam int          OPC_HI      = 23;
   localparam int          OPC_LO      = 20;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_HALT  = 2'd2
   } fetch_state_t;

   function automatic logic [3:0] opcode_of(input logic [DEF_WORD_W-1:0] word);
      return word[OPC_HI:OPC_LO];
   endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_sequencer_if.sv
// ============================================================================
// Module      : fetch_sequencer_if
// Description : Instruction-memory, decode handshake and redirect signals.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_sequencer_if
   import fetch_sequencer_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int WORD_W = DEF_WORD_W
);

   logic [ADDR_W-1:0] INSTR_ADDR;
   logic [WORD_W-1:0] INSTR_WORD;
   logic              FETCH_VALID;
   logic [WORD_W-1:0] FETCH_WORD;
   logic [ADDR_W-1:0] FETCH_PC;
   logic              FETCH_READY;
   logic              BRANCH_TAKEN;
   logic [ADDR_W-1:0] BRANCH_TARGET;
   logic              HALTED;

   modport master (
      output INSTR_ADDR,
      input  INSTR_WORD,
      output FETCH_VALID,
      output FETCH_WORD,
      output FETCH_PC,
      input  FETCH_READY,
      input  BRANCH_TAKEN,
      input  BRANCH_TARGET,
      output HALTED
   );

   modport slave (
      input  INSTR_ADDR,
      output INSTR_WORD,
      input  FETCH_VALID,
      input  FETCH_WORD,
      input  FETCH_PC,
      output FETCH_READY,
      output BRANCH_TAKEN,
      output BRANCH_TARGET,
      input  HALTED
   );

endinterface

`default_nettype wire

// File: rtl/fetch_sequencer_queue.sv
// ============================================================================
// Module      : fetch_queue
// Description : Two-entry FIFO with push, pop and flush; head reads zero when empty.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue #(
   parameter int W     = 30,
   parameter int DEPTH = 2
) (
   input  wire logic         clk,
   input  wire logic         rst,
   input  wire logic         i_push,
   input  wire logic [W-1:0] i_data,
   input  wire logic         i_pop,
   input  wire logic         i_flush,
   output logic      [W-1:0] o_head,
   output logic              o_valid,
   output logic              o_full
);

   logic [W-1:0] r_mem [0:1];
   logic         r_rd;
   logic [1:0]   r_count;
   logic         w_wr;

   // Tail slot: equals the read slot when empty or full, the other slot otherwise.
   assign w_wr    = r_rd ^ r_count[0];
   assign o_valid = (r_count != 2'd0);
   assign o_full  = (r_count == 2'(DEPTH));
   assign o_head  = o_valid ? r_mem[r_rd] : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_rd     <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (i_push) begin
            r_mem[w_wr] <= i_data;
         end
         r_rd <= r_rd ^ i_pop;
         if (i_flush) begin
            r_count <= 2'd0;
         end else begin
            r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ============================================================================
// Module      : fetch_sequencer
// Description : PC owner, fetch/halt state machine and branch arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter int         ADDR_W  = DEF_ADDR_W,
   parameter int         WORD_W  = DEF_WORD_W,
   parameter int         DEPTH   = DEF_DEPTH,
   parameter logic [3:0] HALT_OP = DEF_HALT_OP
) (
   input  wire logic            CLK,
   input  wire logic            RESET,
   fetch_sequencer_if.master    bus
);

   localparam int ENTRY_W = WORD_W + ADDR_W;

   fetch_state_t        r_state;
   logic [ADDR_W-1:0]   r_pc;
   logic                r_halted;

   logic [ENTRY_W-1:0]  w_head;
   logic                w_valid;
   logic                w_full;
   logic                w_pop;
   logic                w_push;
   logic                w_fetch_halt;
   logic                w_head_halt;

   assign w_pop        = w_valid & bus.FETCH_READY;
   assign w_push       = (r_state == ST_RUN) & ~bus.BRANCH_TAKEN & (~w_full | w_pop);
   assign w_fetch_halt = (bus.INSTR_WORD[OPC_HI:OPC_LO] == HALT_OP);
   assign w_head_halt  = (w_head[ENTRY_W-1 -: WORD_W] >> OPC_LO) == WORD_W'(HALT_OP);

   fetch_queue #(
      .W     (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_queue (
      .clk     (CLK),
      .rst     (RESET),
      .i_push  (w_push),
      .i_data  ({bus.INSTR_WORD, r_pc}),
      .i_pop   (w_pop),
      .i_flush (bus.BRANCH_TAKEN),
      .o_head  (w_head),
      .o_valid (w_valid),
      .o_full  (w_full)
   );

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state  <= ST_RUN;
         r_pc     <= '0;
         r_halted <= 1'b0;
      end else if (bus.BRANCH_TAKEN) begin
         r_state  <= ST_RUN;
         r_pc     <= bus.BRANCH_TARGET;
         r_halted <= 1'b0;
      end else begin
         case (r_state)
            ST_RUN: begin
               // A fetched halt word is queued but the PC stays on it.
               if (w_push) begin
                  if (w_fetch_halt) begin
                     r_state <= ST_DRAIN;
                  end else begin
                     r_pc <= r_pc + ADDR_W'(1);
                  end
               end
            end
            ST_DRAIN: begin
               if (w_pop && w_head_halt) begin
                  r_state  <= ST_HALT;
                  r_halted <= 1'b1;
               end
            end
            ST_HALT: begin
               r_halted <= 1'b1;
            end
            default: begin
               r_state <= ST_RUN;
            end
         endcase
      end
   end

   assign bus.INSTR_ADDR  = r_pc;
   assign bus.FETCH_VALID = w_valid;
   assign bus.FETCH_WORD  = w_head[ENTRY_W-1 -: WORD_W];
   assign bus.FETCH_PC    = w_head[ADDR_W-1:0];
   assign bus.HALTED      = r_halted;

endmodule

`default_nettype wire
